rsa_modexp_core: RTL and testbench

Parametrised Montgomery modular-exponentiation engine computing Z = X^E mod N for BITS-wide operands, the next-generation replacement for the fixed 64-bit exponentiator in the RSA encryption datapath. It sits between the operand memory (which supplies X, E, N and R2) and the result latch. It adds a parameterised width, a busy/err status, an abort input and a single-cycle done pulse with a held result. Internally it uses a bit-serial radix-2 Montgomery multiplier sequenced by left-to-right square-and-multiply.

---
 rtl/rsa_modexp_core_if.sv | 20 ++
 rtl/rsa_modexp_core.sv | 174 +++++++++++++++++
 tb/tb_rsa_modexp_core.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_core_if.sv
// Operand/status bundle between the operand memory, the exponentiator and the result latch.
// Latency: none, wires only.
// Backpressure: none; the host watches busy and only pulses go when the engine is idle.
interface rsa_modexp_core_if #(
    parameter int BITS = 64
);
    logic            go;
    logic            abort;
    logic [BITS-1:0] X;
    logic [BITS-1:0] E;
    logic [BITS-1:0] N;
    logic [BITS-1:0] R2;
    logic            busy;
    logic            done;
    logic            err;
    logic [BITS-1:0] Z;

    modport master (output go, abort, X, E, N, R2, input busy, done, err, Z);
    modport slave  (input go, abort, X, E, N, R2, output busy, done, err, Z);
endinterface

// File: rtl/rsa_modexp_core.sv
// Montgomery modular exponentiation Z = X^E mod N, bit-serial radix-2 MontMul, left-to-right square-and-multiply.
// Latency: done at accept + 1 + (BITS+1)*(3 + BITS + popcount(E)); err at accept + 2.
// Backpressure: go ignored while busy; abort drops the run without a done/err pulse.
module rsa_modexp_core #(
    parameter int BITS = 64
) (
    input  logic              clk,
    input  logic              reset,
    rsa_modexp_core_if.slave  bus
);
    localparam int CW = $clog2(BITS + 1);
    localparam int IW = $clog2(BITS);
    localparam int TW = BITS + 2;

    localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE, CONV_X, CONV_ONE, SQR, MUL, FINAL, DONE
    } state_t;

    state_t          r_state, w_next;

    logic [BITS-1:0] r_e, r_n, r_r2;     // captured operands
    logic [BITS-1:0] r_xm;               // X in Montgomery form
    logic [BITS-1:0] r_a;                // running accumulator, final result after FINAL
    logic [BITS-1:0] r_ash;              // A operand of the current MontMul, consumed LSB first
    logic [TW-1:0]   r_t;                // MontMul partial sum
    logic [CW-1:0]   r_cnt;              // cycles left in the current MontMul (0 = correction)
    logic [IW-1:0]   r_idx;              // exponent bit being processed
    logic [BITS-1:0] r_z;
    logic            r_busy, r_done, r_err;

    logic            w_start, w_op_end, w_idx_dec, w_done_p, w_err_p, w_bad;
    logic [BITS-1:0] w_b, w_res;
    logic [TW-1:0]   w_sum, w_sum_q, w_t_step;

    // An even modulus (zero included) has no Montgomery inverse of 2.
    assign w_bad = ~r_n[0];

    // MontMul datapath: B operand select, one radix-2 step and the final conditional subtract.
    always_comb begin
        w_b = r_a;
        case (r_state)
            CONV_X, CONV_ONE: w_b = r_r2;
            MUL:              w_b = r_xm;
            FINAL:            w_b = ONE;
            default:          w_b = r_a;
        endcase
        w_sum    = r_t + (r_ash[0] ? {2'b00, w_b} : {TW{1'b0}});
        w_sum_q  = w_sum[0] ? (w_sum + {2'b00, r_n}) : w_sum;
        w_t_step = w_sum_q >> 1;
        w_res    = (r_t >= {2'b00, r_n}) ? BITS'(r_t - {2'b00, r_n}) : r_t[BITS-1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next state and per-cycle control strobes; abort overrides everything outside IDLE.
    always_comb begin
        w_next    = r_state;
        w_start   = 1'b0;
        w_op_end  = 1'b0;
        w_idx_dec = 1'b0;
        w_done_p  = 1'b0;
        w_err_p   = 1'b0;
        if (r_state != IDLE && bus.abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (bus.go) begin
                    w_start = 1'b1;
                    w_next  = CONV_X;
                end
                CONV_X: if (w_bad) begin
                    w_next = DONE;
                end else if (r_cnt == '0) begin
                    w_op_end = 1'b1;
                    w_next   = CONV_ONE;
                end
                CONV_ONE: if (r_cnt == '0) begin
                    w_op_end = 1'b1;
                    w_next   = SQR;
                end
                SQR: if (r_cnt == '0) begin
                    w_op_end = 1'b1;
                    if (r_e[r_idx]) begin
                        w_next = MUL;
                    end else begin
                        w_idx_dec = 1'b1;
                        w_next    = (r_idx == '0) ? FINAL : SQR;
                    end
                end
                MUL: if (r_cnt == '0) begin
                    w_op_end  = 1'b1;
                    w_idx_dec = 1'b1;
                    w_next    = (r_idx == '0) ? FINAL : SQR;
                end
                FINAL: if (r_cnt == '0) begin
                    w_op_end = 1'b1;
                    w_next   = DONE;
                end
                DONE: begin
                    w_done_p = ~w_bad;
                    w_err_p  = w_bad;
                    w_next   = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Operand capture, MontMul stepping and op-to-op hand-off of results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e   <= '0;
            r_n   <= '0;
            r_r2  <= '0;
            r_xm  <= '0;
            r_a   <= '0;
            r_ash <= '0;
            r_t   <= '0;
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_start) begin
            r_e   <= bus.E;
            r_n   <= bus.N;
            r_r2  <= bus.R2;
            r_ash <= bus.X;
            r_t   <= '0;
            r_cnt <= CW'(BITS);
            r_idx <= IW'(BITS - 1);
        end else if (w_op_end) begin
            r_t   <= '0;
            r_cnt <= CW'(BITS);
            if (r_state == CONV_X) begin
                r_xm  <= w_res;
                r_ash <= ONE;
            end else begin
                r_a   <= w_res;
                r_ash <= w_res;
            end
            if (w_idx_dec)
                r_idx <= (r_idx == '0) ? IW'(BITS - 1) : r_idx - 1'b1;
        end else if (r_state inside {CONV_X, CONV_ONE, SQR, MUL, FINAL} && r_cnt != '0) begin
            r_t   <= w_t_step;
            r_ash <= r_ash >> 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Status and result; busy lags the accept by one edge and falls on the closing edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_z    <= '0;
        end else begin
            r_busy <= (r_state != IDLE) && (w_next != IDLE);
            r_done <= w_done_p;
            r_err  <= w_err_p;
            if (w_done_p)     r_z <= r_a;
            else if (w_err_p) r_z <= '0;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.err  = r_err;
    assign bus.Z    = r_z;
endmodule

// File: tb/tb_rsa_modexp_core.sv
// Bench for rsa_modexp_core: directed vectors at 16 bits plus random runs at 16 and 64 bits.
// Latency: results compared against an arithmetic square-and-multiply model.
// Backpressure: exercises go-while-busy, abort and asynchronous reset mid-run.
module tb_rsa_modexp_core;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    rsa_modexp_core_if #(.BITS(16)) bus16 ();
    rsa_modexp_core_if #(.BITS(64)) bus64 ();

    rsa_modexp_core #(.BITS(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    rsa_modexp_core #(.BITS(64)) dut64 (.clk(clk), .reset(reset), .bus(bus64));

    // Reference: plain modular square-and-multiply on wide integers.
    function automatic logic [127:0] ref_modexp(input logic [127:0] x, input logic [127:0] e,
                                                input logic [127:0] n, input int bits);
        logic [127:0] r, b;
        r = 128'd1 % n;
        b = x % n;
        for (int i = bits - 1; i >= 0; i--) begin
            r = (r * r) % n;
            if (e[i]) r = (r * b) % n;
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_r2(input logic [127:0] n, input int bits);
        logic [127:0] t;
        t = (128'd1 << bits) % n;
        return (t * t) % n;
    endfunction

    function automatic int ref_lat(input logic [127:0] e, input int bits);
        return 1 + (bits + 1) * (3 + bits + $countones(e));
    endfunction

    // Starts one 16-bit run and follows it to done/err; reports cycles after the accept edge.
    task automatic run16(input logic [15:0] x, input logic [15:0] e, input logic [15:0] n,
                         input logic [15:0] r2, input bit with_abort,
                         output int lat, output bit got_err, output bit busy_ok, output bit z_held);
        logic [15:0] z0;
        @(negedge clk);
        z0 = bus16.Z;
        bus16.go = 1'b1; bus16.abort = with_abort;
        bus16.X = x; bus16.E = e; bus16.N = n; bus16.R2 = r2;
        @(posedge clk);
        @(negedge clk);
        bus16.go = 1'b0; bus16.abort = 1'b0;
        bus16.X = 16'($urandom); bus16.E = 16'($urandom);
        bus16.N = 16'($urandom); bus16.R2 = 16'($urandom);
        lat = -1; got_err = 1'b0; busy_ok = 1'b1; z_held = 1'b1;
        for (int c = 1; c <= 20000; c++) begin
            @(negedge clk);
            if (bus16.done || bus16.err) begin
                lat = c;
                got_err = bus16.err;
                break;
            end
            if (!bus16.busy) busy_ok = 1'b0;
            if (bus16.Z !== z0) z_held = 1'b0;
        end
    endtask

    task automatic run64(input logic [63:0] x, input logic [63:0] e, input logic [63:0] n,
                         input logic [63:0] r2, output int lat);
        @(negedge clk);
        bus64.go = 1'b1; bus64.X = x; bus64.E = e; bus64.N = n; bus64.R2 = r2;
        @(posedge clk);
        @(negedge clk);
        bus64.go = 1'b0;
        bus64.X = {$urandom, $urandom}; bus64.E = {$urandom, $urandom};
        lat = -1;
        for (int c = 1; c <= 20000; c++) begin
            @(negedge clk);
            if (bus64.done || bus64.err) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_total++;
        if ({bus16.busy, bus16.done, bus16.err, bus16.Z} !== 19'd0)
            $display("FAIL reset16_in: got %b/%b/%b/%0d required 0/0/0/0", bus16.busy, bus16.done, bus16.err, bus16.Z);
        else n_pass++;
        n_total++;
        if ({bus64.busy, bus64.done, bus64.err, bus64.Z} !== 67'd0)
            $display("FAIL reset64_in: got %b/%b/%b/%0d required 0/0/0/0", bus64.busy, bus64.done, bus64.err, bus64.Z);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus16.busy, bus16.done, bus16.err, bus16.Z} !== 19'd0)
            $display("FAIL reset16_out: got %b/%b/%b/%0d required 0/0/0/0", bus16.busy, bus16.done, bus16.err, bus16.Z);
        else n_pass++;
    endtask

    task automatic test_known;
        int lat; bit ge, bok, zh;
        run16(16'd65, 16'd17, 16'd3233, 16'd1155, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (lat !== 358) $display("FAIL known_lat: got %0d required 358", lat); else n_pass++;
        n_total++;
        if (bus16.Z !== 16'd2790 || ge) $display("FAIL known_z: got %0d err=%b required 2790", bus16.Z, ge); else n_pass++;
        n_total++;
        if (!bok || bus16.busy !== 1'b0) $display("FAIL known_busy: got during=%b at_done=%b required 1/0", bok, bus16.busy); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int lat; bit ge, bok, zh;
        run16(16'd2790, 16'd2753, 16'd3233, 16'd1155, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (lat !== ref_lat(128'd2753, 16)) $display("FAIL b2b_lat: got %0d required %0d", lat, ref_lat(128'd2753, 16)); else n_pass++;
        n_total++;
        if (bus16.Z !== 16'd65) $display("FAIL b2b_z: got %0d required 65", bus16.Z); else n_pass++;
        n_total++;
        if (!zh) $display("FAIL b2b_zheld: got held=%b required 1", zh); else n_pass++;
    endtask

    task automatic test_err;
        int lat; bit ge, bok, zh;
        run16(16'd65, 16'd17, 16'd3232, 16'd1155, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (lat !== 2 || !ge) $display("FAIL err_pulse: got lat=%0d err=%b required 2/1", lat, ge); else n_pass++;
        n_total++;
        if (bus16.Z !== 16'd0 || bus16.done !== 1'b0 || bus16.busy !== 1'b0)
            $display("FAIL err_state: got z=%0d done=%b busy=%b required 0/0/0", bus16.Z, bus16.done, bus16.busy);
        else n_pass++;
        n_total++;
        if (!bok) $display("FAIL err_busy: got busy_during=%b required 1", bok); else n_pass++;
        run16(16'd65, 16'd17, 16'd3233, 16'd1155, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (bus16.Z !== 16'd2790 || lat !== 358) $display("FAIL err_recover: got z=%0d lat=%0d required 2790/358", bus16.Z, lat); else n_pass++;
    endtask

    task automatic test_edge_values;
        int lat; bit ge, bok, zh;
        run16(16'd123, 16'd0, 16'd3233, 16'd1155, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (bus16.Z !== 16'd1 || lat !== 324) $display("FAIL e0: got z=%0d lat=%0d required 1/324", bus16.Z, lat); else n_pass++;
        run16(16'd0, 16'd5, 16'd1, 16'd0, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (bus16.Z !== 16'd0 || ge || lat !== ref_lat(128'd5, 16))
            $display("FAIL n1: got z=%0d err=%b lat=%0d required 0/0/%0d", bus16.Z, ge, lat, ref_lat(128'd5, 16));
        else n_pass++;
        run16(16'd0, 16'd17, 16'd3233, 16'd1155, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (bus16.Z !== 16'd0) $display("FAIL x0: got %0d required 0", bus16.Z); else n_pass++;
        // go and abort together in IDLE: the run must proceed.
        run16(16'd65, 16'd17, 16'd3233, 16'd1155, 1'b1, lat, ge, bok, zh);
        n_total++;
        if (bus16.Z !== 16'd2790 || lat !== 358) $display("FAIL go_abort_idle: got z=%0d lat=%0d required 2790/358", bus16.Z, lat); else n_pass++;
    endtask

    task automatic test_abort;
        logic [15:0] z0;
        bit seen = 1'b0;
        @(negedge clk);
        z0 = bus16.Z;
        bus16.go = 1'b1; bus16.X = 16'd2790; bus16.E = 16'd2753; bus16.N = 16'd3233; bus16.R2 = 16'd1155;
        @(posedge clk);
        @(negedge clk);
        bus16.go = 1'b0;
        repeat (100) @(negedge clk);
        n_total++;
        if (bus16.busy !== 1'b1) $display("FAIL abort_pre: got busy=%b required 1", bus16.busy); else n_pass++;
        bus16.abort = 1'b1;
        @(negedge clk);
        bus16.abort = 1'b0;
        n_total++;
        if (bus16.busy !== 1'b0) $display("FAIL abort_busy: got busy=%b required 0", bus16.busy); else n_pass++;
        for (int c = 0; c < 450; c++) begin
            @(negedge clk);
            if (bus16.done || bus16.err || bus16.busy) seen = 1'b1;
        end
        n_total++;
        if (seen || bus16.Z !== z0) $display("FAIL abort_quiet: got activity=%b z=%0d required 0/%0d", seen, bus16.Z, z0); else n_pass++;
    endtask

    task automatic test_go_ignored;
        int lat = -1;
        @(negedge clk);
        bus16.go = 1'b1; bus16.X = 16'd65; bus16.E = 16'd17; bus16.N = 16'd3233; bus16.R2 = 16'd1155;
        @(posedge clk);
        @(negedge clk);
        bus16.go = 1'b0;
        for (int c = 1; c <= 20000; c++) begin
            @(negedge clk);
            if (c == 50) begin
                bus16.go = 1'b1; bus16.X = 16'd7; bus16.E = 16'hFFFF;
            end
            if (c == 51) bus16.go = 1'b0;
            if (bus16.done || bus16.err) begin
                lat = c;
                break;
            end
        end
        n_total++;
        if (lat !== 358 || bus16.Z !== 16'd2790) $display("FAIL go_busy: got lat=%0d z=%0d required 358/2790", lat, bus16.Z); else n_pass++;
    endtask

    task automatic test_async_reset;
        int lat; bit ge, bok, zh;
        @(negedge clk);
        bus16.go = 1'b1; bus16.X = 16'd2790; bus16.E = 16'd2753; bus16.N = 16'd3233; bus16.R2 = 16'd1155;
        @(posedge clk);
        @(negedge clk);
        bus16.go = 1'b0;
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({bus16.busy, bus16.done, bus16.err, bus16.Z} !== 19'd0)
            $display("FAIL async_reset: got %b/%b/%b/%0d required 0/0/0/0", bus16.busy, bus16.done, bus16.err, bus16.Z);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        run16(16'd65, 16'd17, 16'd3233, 16'd1155, 1'b0, lat, ge, bok, zh);
        n_total++;
        if (bus16.Z !== 16'd2790 || lat !== 358) $display("FAIL post_reset: got z=%0d lat=%0d required 2790/358", bus16.Z, lat); else n_pass++;
    endtask

    task automatic test_random16;
        int lat; bit ge, bok, zh;
        logic [15:0] n, x, e, r2, zexp;
        for (int i = 0; i < 30; i++) begin
            n    = 16'($urandom) | 16'd1;
            x    = 16'($urandom % n);
            e    = 16'($urandom);
            r2   = 16'(ref_r2(128'(n), 16));
            zexp = 16'(ref_modexp(128'(x), 128'(e), 128'(n), 16));
            run16(x, e, n, r2, 1'b0, lat, ge, bok, zh);
            n_total++;
            if (bus16.Z !== zexp || lat !== ref_lat(128'(e), 16) || ge)
                $display("FAIL rand16[%0d]: x=%0d e=%0d n=%0d got z=%0d lat=%0d required z=%0d lat=%0d",
                         i, x, e, n, bus16.Z, lat, zexp, ref_lat(128'(e), 16));
            else n_pass++;
        end
    endtask

    task automatic test_random64;
        int lat;
        logic [63:0] n, x, e, r2, zexp;
        for (int i = 0; i < 3; i++) begin
            n    = {$urandom, $urandom} | 64'd1;
            x    = 64'(128'({$urandom, $urandom}) % 128'(n));
            e    = {$urandom, $urandom};
            r2   = 64'(ref_r2(128'(n), 64));
            zexp = 64'(ref_modexp(128'(x), 128'(e), 128'(n), 64));
            run64(x, e, n, r2, lat);
            n_total++;
            if (bus64.Z !== zexp || lat !== ref_lat(128'(e), 64))
                $display("FAIL rand64[%0d]: got z=%h lat=%0d required z=%h lat=%0d", i, bus64.Z, lat, zexp, ref_lat(128'(e), 64));
            else n_pass++;
        end
    endtask

    initial begin
        bus16.go = 1'b0; bus16.abort = 1'b0;
        bus16.X = '0; bus16.E = '0; bus16.N = '0; bus16.R2 = '0;
        bus64.go = 1'b0; bus64.abort = 1'b0;
        bus64.X = '0; bus64.E = '0; bus64.N = '0; bus64.R2 = '0;
        test_reset();
        test_known();
        test_back_to_back();
        test_err();
        test_edge_values();
        test_abort();
        test_go_ignored();
        test_async_reset();
        test_random16();
        test_random64();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
